// File: rtl/rr_mux_pkg.sv
// Shared constants and state type for the round-robin 8:1 mux arbiter.
package rr_mux_pkg;

    localparam int NUM_REQ     = 8;
    localparam int SEL_W       = 3;
    localparam int BURST_CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/mux8x1.sv
// Single-bit 8:1 multiplexer; the arbiter's data path is a bit-sliced array of these.
module mux8x1
    import rr_mux_pkg::*;
(
    input  logic [NUM_REQ-1:0] d,
    input  logic [SEL_W-1:0]   s,
    output logic               y
);

    assign y = d[s];

endmodule

// File: rtl/rr_pick8.sv
// Rotating-priority encoder: returns the first set req bit found scanning upward
// from start and wrapping modulo 8.
module rr_pick8
    import rr_mux_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   start,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [SEL_W-1:0]     offset;

    // Rotating by start puts the highest-priority requester at bit 0.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[start +: NUM_REQ];
    assign any     = |req;

    // NOTE: give every always_comb output a value before any branch, otherwise a latch is inferred.
    always_comb begin
        offset = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = SEL_W'(i);
            end
        end
    end

    assign idx = start + offset;

endmodule

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter feeding an 8:1 data mux into a registered valid/ready output stage,
// with optional bursting of up to BURST consecutive words per requester.
module rr_mux8_arbiter
    import rr_mux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int BURST  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] din,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [SEL_W-1:0]          out_sel
);

    localparam logic [BURST_CNT_W-1:0] BURST_LIM = BURST_CNT_W'(BURST - 1);

    state_t                 state;
    state_t                 state_nxt;
    logic [SEL_W-1:0]       last;
    logic [BURST_CNT_W-1:0] burst_cnt;
    logic [SEL_W-1:0]       scan_idx;
    logic [SEL_W-1:0]       pick;
    logic [DATA_W-1:0]      mux_out;
    logic                   any_req;
    logic                   continue_burst;
    logic                   load_en;

    rr_pick8 u_pick (
        .req   (req),
        .start (last + SEL_W'(1)),
        .any   (any_req),
        .idx   (scan_idx)
    );

    assign continue_burst = (BURST > 1) && req[last] && (burst_cnt < BURST_LIM);
    assign pick           = continue_burst ? last : scan_idx;

    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
        logic [NUM_REQ-1:0] col;
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_col
            assign col[k] = din[k*DATA_W + b];
        end
        mux8x1 u_mux (
            .d (col),
            .s (pick),
            .y (mux_out[b])
        );
    end

    // Gating with rst_n keeps ack low for the whole reset window, not just after the first edge.
    always_comb begin
        state_nxt = state;
        load_en   = 1'b0;
        ack       = '0;
        unique case (state)
            IDLE: load_en = any_req;
            SEND: begin
                if (out_ready) begin
                    load_en = any_req;
                    if (!any_req) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        load_en = load_en & rst_n;
        if (load_en) begin
            state_nxt = SEND;
            ack[pick] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= SEL_W'(NUM_REQ - 1);
            burst_cnt <= '0;
            out_data  <= '0;
        end else begin
            state <= state_nxt;
            if (load_en) begin
                out_data  <= mux_out;
                last      <= pick;
                burst_cnt <= continue_burst ? burst_cnt + BURST_CNT_W'(1) : '0;
            end
        end
    end

    assign out_valid = (state == SEND);
    assign out_sel   = last;

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Scoreboard bench: one strict round-robin instance (BURST=1) and one bursting instance (BURST=3).
module tb_rr_mux8_arbiter;

    localparam int DW = 8;

    typedef struct packed {
        logic [2:0]    sel;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n_a, rst_n_b;
    logic [7:0]      req_a, req_b, ack_a, ack_b;
    logic [8*DW-1:0] din_a, din_b;
    logic            ready_a, ready_b, valid_a, valid_b;
    logic [DW-1:0]   data_a, data_b;
    logic [2:0]      sel_a, sel_b;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    int   checks = 0;
    int   errors = 0;

    rr_mux8_arbiter #(.DATA_W(DW), .BURST(1)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .req(req_a), .din(din_a), .ack(ack_a),
        .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a), .out_sel(sel_a)
    );

    rr_mux8_arbiter #(.DATA_W(DW), .BURST(3)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .req(req_b), .din(din_b), .ack(ack_b),
        .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b), .out_sel(sel_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8*DW-1:0] pattern();
        logic [8*DW-1:0] v;
        for (int k = 0; k < 8; k++) v[k*DW +: DW] = DW'(16 * k + 3);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_load_a(input int p);
        #1;
        check("a_ack", 32'(ack_a), 32'(1) << p);
        q_a.push_back('{sel: 3'(p), data: din_a[p*DW +: DW]});
    endtask

    task automatic expect_load_b(input int p);
        #1;
        check("b_ack", 32'(ack_b), 32'(1) << p);
        q_b.push_back('{sel: 3'(p), data: din_b[p*DW +: DW]});
    endtask

    // Consumption happens at the next rising edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n_a && valid_a && ready_a) begin
            if (q_a.size() == 0) check("a_unexpected_word", 32'(sel_a), 32'hFFFF);
            else begin
                e_a = q_a.pop_front();
                check("a_sel", 32'(sel_a), 32'(e_a.sel));
                check("a_data", 32'(data_a), 32'(e_a.data));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n_b && valid_b && ready_b) begin
            if (q_b.size() == 0) check("b_unexpected_word", 32'(sel_b), 32'hFFFF);
            else begin
                e_b = q_b.pop_front();
                check("b_sel", 32'(sel_b), 32'(e_b.sel));
                check("b_data", 32'(data_b), 32'(e_b.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int seq_b[$];
        rst_n_a = 1'b0; rst_n_b = 1'b0;
        req_a = '0; req_b = '0; din_a = '0; din_b = '0;
        ready_a = 1'b0; ready_b = 1'b0;
        tick(); tick();

        // Reset values, and ack held low in reset even with requests pending.
        check("a_rst_valid", 32'(valid_a), 0);
        check("a_rst_sel", 32'(sel_a), 7);
        check("a_rst_data", 32'(data_a), 0);
        check("b_rst_sel", 32'(sel_b), 7);
        req_a = 8'hFF;
        #1;
        check("a_rst_ack", 32'(ack_a), 0);
        req_a = '0;
        rst_n_a = 1'b1;
        tick();

        // Single request: same-cycle ack, registered word one cycle later.
        din_a[7:0] = 8'hA5;
        req_a = 8'h01; ready_a = 1'b1;
        expect_load_a(0);
        tick();
        req_a = '0;
        din_a = pattern();
        check("a_first_valid", 32'(valid_a), 1);
        check("a_first_data", 32'(data_a), 32'hA5);
        check("a_first_sel", 32'(sel_a), 0);
        #1;
        check("a_idle_ack", 32'(ack_a), 0);
        tick();
        check("a_back_idle", 32'(valid_a), 0);

        // All requesting: rotation continues from last=0.
        req_a = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            expect_load_a((1 + i) % 8);
            tick();
        end
        req_a = '0;
        tick();
        check("a_rr_drained", 32'(valid_a), 0);

        // Back-pressure: source 0 frozen, then source 7 next.
        rst_n_a = 1'b0; #1; rst_n_a = 1'b1;
        tick();
        req_a = 8'h81; ready_a = 1'b0;
        expect_load_a(0);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("a_hold_ack", 32'(ack_a), 0);
            check("a_hold_sel", 32'(sel_a), 0);
            check("a_hold_data", 32'(data_a), 32'(din_a[DW-1:0]));
            check("a_hold_valid", 32'(valid_a), 1);
            tick();
        end
        ready_a = 1'b1;
        expect_load_a(7);
        tick();
        req_a = '0;
        tick();
        check("a_hold_drained", 32'(valid_a), 0);

        // Reset while a word is held: dropped immediately, then fresh priority from 0.
        req_a = 8'h20; ready_a = 1'b0;
        expect_load_a(5);
        tick();
        check("a_pre_rst_valid", 32'(valid_a), 1);
        rst_n_a = 1'b0;
        #1;
        check("a_midrst_valid", 32'(valid_a), 0);
        check("a_midrst_sel", 32'(sel_a), 7);
        check("a_midrst_data", 32'(data_a), 0);
        check("a_midrst_ack", 32'(ack_a), 0);
        q_a.delete();
        tick();
        rst_n_a = 1'b1;
        req_a = 8'h10; ready_a = 1'b1;
        expect_load_a(4);
        tick();
        req_a = '0;
        tick();
        check("a_end_valid", 32'(valid_a), 0);

        // Bursting: 1,1,1,2,2,2,1,1 then req drops to source 2 mid-burst.
        rst_n_b = 1'b1;
        din_b = pattern();
        ready_b = 1'b1;
        req_b = 8'h06;
        seq_b = '{1, 1, 1, 2, 2, 2, 1, 1};
        foreach (seq_b[i]) begin
            expect_load_b(seq_b[i]);
            tick();
        end
        req_b = 8'h04;
        expect_load_b(2);
        tick();
        req_b = 8'h06;
        seq_b = '{2, 2, 1};
        foreach (seq_b[i]) begin
            expect_load_b(seq_b[i]);
            tick();
        end
        req_b = '0;
        tick();
        check("b_end_valid", 32'(valid_b), 0);

        check("a_queue_empty", 32'(q_a.size()), 0);
        check("b_queue_empty", 32'(q_b.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
